// File: rtl/alu_pkg.sv
// Shared opcode and state encodings for the
// sequential ALU and its iterative datapath.
package alu_pkg;

  localparam logic [31:0] OP_ROL  = 32'd0;
  localparam logic [31:0] OP_SLL  = 32'd1;
  localparam logic [31:0] OP_ROR  = 32'd2;
  localparam logic [31:0] OP_SRL  = 32'd3;
  localparam logic [31:0] OP_ADD  = 32'd4;
  localparam logic [31:0] OP_OR   = 32'd5;
  localparam logic [31:0] OP_XOR  = 32'd6;
  localparam logic [31:0] OP_AND  = 32'd7;
  localparam logic [31:0] OP_MUL  = 32'd8;
  localparam logic [31:0] OP_DIVU = 32'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative unsigned multiply (shift-add) and
// restoring divide, one step per cycle.
module alu_iter_muldiv
  import alu_pkg::*;
#(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic         mode_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic         done_o,
  output logic [N-1:0] lo_o,
  output logic [N-1:0] hi_o
);

  localparam int CW = $clog2(N) + 1;

  logic [2*N-1:0] acc_q, acc_d;
  logic [N-1:0]   b_q;
  logic [CW-1:0]  cnt_q;
  logic           mode_q;
  logic           busy_q;

  logic [N:0]     msum;
  logic [N:0]     rem;
  logic [N:0]     rem_s;
  logic           qbit;

  // One multiply or divide step on the current accumulator
  always_comb begin
    msum  = {1'b0, acc_q[2*N-1:N]}
          + (acc_q[0] ? {1'b0, b_q} : '0);
    rem   = {acc_q[2*N-1:N], acc_q[N-1]};
    rem_s = rem - {1'b0, b_q};
    qbit  = (rem >= {1'b0, b_q});
    if (mode_q) begin
      acc_d = qbit
        ? {rem_s[N-1:0], acc_q[N-2:0], 1'b1}
        : {rem[N-1:0], acc_q[N-2:0], 1'b0};
    end else begin
      acc_d = {msum, acc_q[N-1:1]};
    end
  end

  // Load operands on start, then iterate N times
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      b_q    <= '0;
      cnt_q  <= '0;
      mode_q <= 1'b0;
      busy_q <= 1'b0;
    end else if (start_i) begin
      acc_q  <= {{N{1'b0}}, a_i};
      b_q    <= b_i;
      cnt_q  <= CW'(N);
      mode_q <= mode_i;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      acc_q <= acc_d;
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == CW'(1)) busy_q <= 1'b0;
    end
  end

  // Result of the final step, valid with done_o
  assign done_o = busy_q && (cnt_q == CW'(1));
  assign lo_o   = acc_d[N-1:0];
  assign hi_o   = acc_d[2*N-1:N];

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle shift/logic/add
// plus iterative MUL/DIVU behind valid/ready.
module alu_seq
  import alu_pkg::*;
#(
  parameter int N  = 16,
  parameter int O  = 4,
  parameter int SW = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  input  logic [O-1:0] Op,
  input  logic         invA,
  input  logic         invB,
  input  logic         sign,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Out,
  output logic [N-1:0] OutHi,
  output logic         Ofl,
  output logic         Zero,
  output logic         Neg,
  output logic         err
);

  state_t state_q, state_d;

  logic [N-1:0] out_q, out_d;
  logic [N-1:0] hi_q, hi_d;
  logic         ofl_q, ofl_d;
  logic         err_q, err_d;
  logic         zero_q, neg_q;
  logic         mode_q, mode_d;
  logic         ld;

  logic [31:0]  op_w;
  logic [N-1:0] a_e, b_e;
  logic [SW-1:0] sh;
  logic [SW:0]  nsh;
  logic [N:0]   sum_w;
  logic [N-1:0] sc_out, sc_hi;
  logic         sc_ofl, sc_err;
  logic         is_mul, is_div, b_zero, long_op;

  logic         md_start, md_done;
  logic [N-1:0] md_lo, md_hi;

  assign op_w    = 32'(Op);
  assign a_e     = invA ? ~A : A;
  assign b_e     = invB ? ~B : B;
  assign sh      = B[SW-1:0];
  assign nsh     = (SW+1)'(N) - {1'b0, sh};
  assign sum_w   = {1'b0, a_e} + {1'b0, b_e}
                 + {{N{1'b0}}, Cin};
  assign b_zero  = (B == '0);
  assign is_mul  = (op_w == OP_MUL);
  assign is_div  = (op_w == OP_DIVU);
  assign long_op = is_mul || (is_div && !b_zero);

  // Single-cycle result straight from the inputs
  always_comb begin
    sc_out = '0;
    sc_hi  = '0;
    sc_ofl = 1'b0;
    sc_err = 1'b0;
    case (op_w)
      OP_ROL: sc_out = (A << sh) | (A >> nsh);
      OP_SLL: sc_out = A << sh;
      OP_ROR: sc_out = (A >> sh) | (A << nsh);
      OP_SRL: sc_out = A >> sh;
      OP_ADD: begin
        sc_out = sum_w[N-1:0];
        sc_ofl = sign
          ? (a_e[N-1] == b_e[N-1]) &&
            (sum_w[N-1] != a_e[N-1])
          : sum_w[N];
      end
      OP_OR:  sc_out = a_e | b_e;
      OP_XOR: sc_out = a_e ^ b_e;
      OP_AND: sc_out = a_e & b_e;
      OP_DIVU: begin
        sc_out = '1;
        sc_hi  = A;
        sc_err = 1'b1;
      end
      default: sc_err = 1'b1;
    endcase
  end

  // Next state and result load decisions
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    ld       = 1'b0;
    md_start = 1'b0;
    out_d    = '0;
    hi_d     = '0;
    ofl_d    = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (long_op) begin
            md_start = 1'b1;
            mode_d   = is_div;
            state_d  = ST_BUSY;
          end else begin
            ld      = 1'b1;
            out_d   = sc_out;
            hi_d    = sc_hi;
            ofl_d   = sc_ofl;
            err_d   = sc_err;
            state_d = ST_DONE;
          end
        end
      end
      ST_BUSY: begin
        if (md_done) begin
          ld      = 1'b1;
          out_d   = md_lo;
          hi_d    = md_hi;
          ofl_d   = !mode_q && (md_hi != '0);
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register and result registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      mode_q  <= 1'b0;
      out_q   <= '0;
      hi_q    <= '0;
      ofl_q   <= 1'b0;
      err_q   <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      if (ld) begin
        out_q  <= out_d;
        hi_q   <= hi_d;
        ofl_q  <= ofl_d;
        err_q  <= err_d;
        zero_q <= (out_d == '0);
        neg_q  <= out_d[N-1];
      end
    end
  end

  alu_iter_muldiv #(.N(N)) u_md (
    .clk     (clk),
    .rst_n   (rst),
    .start_i (md_start),
    .mode_i  (is_div),
    .a_i     (A),
    .b_i     (B),
    .done_o  (md_done),
    .lo_o    (md_lo),
    .hi_o    (md_hi)
  );

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign Out       = out_q;
  assign OutHi     = hi_q;
  assign Ofl       = ofl_q;
  assign Zero      = zero_q;
  assign Neg       = neg_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with hand-computed
// results, latencies and handshake checks.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic        Cin = 1'b0;
  logic [3:0]  Op = '0;
  logic        invA = 1'b0;
  logic        invB = 1'b0;
  logic        sign = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] Out;
  logic [15:0] OutHi;
  logic        Ofl;
  logic        Zero;
  logic        Neg;
  logic        err;

  int total = 0;
  int bad = 0;
  int lat;
  int bz;

  always #5 clk = ~clk;

  alu_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .Op        (Op),
    .invA      (invA),
    .invB      (invB),
    .sign      (sign),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Out       (Out),
    .OutHi     (OutHi),
    .Ofl       (Ofl),
    .Zero      (Zero),
    .Neg       (Neg),
    .err       (err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h",
             tag, got, exp);
    end
  endtask

  // Present one op at negedge, accepted at next posedge
  task automatic send(input logic [3:0] op,
                      input logic [15:0] a,
                      input logic [15:0] b,
                      input logic ci,
                      input logic ia,
                      input logic ib,
                      input logic sg);
    @(negedge clk);
    Op = op; A = a; B = b; Cin = ci;
    invA = ia; invB = ib; sign = sg;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Edges from accept until out_valid, incl. accept edge
  task automatic wait_done(output int l,
                           output int busy);
    l = 1;
    busy = 0;
    while (!out_valid && l < 40) begin
      if (!in_ready) busy++;
      @(posedge clk);
      #1;
      l++;
    end
  endtask

  task automatic take();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("clear_valid", 32'(out_valid), 0);
    chk("ready_back", 32'(in_ready), 1);
  endtask

  initial begin
    #3;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out", 32'(Out), 0);
    chk("rst_outhi", 32'(OutHi), 0);
    chk("rst_flags",
        {28'd0, Ofl, Zero, Neg, err}, 0);
    @(negedge clk);
    rst = 1'b1;

    send(4'd4, 16'h7FFF, 16'h0001, 0, 0, 0, 1);
    wait_done(lat, bz);
    chk("add_s_lat", lat, 1);
    chk("add_s_out", 32'(Out), 32'h8000);
    chk("add_s_ofl", 32'(Ofl), 1);
    chk("add_s_neg", 32'(Neg), 1);
    chk("add_s_zero", 32'(Zero), 0);
    take();

    send(4'd4, 16'h7FFF, 16'h0001, 0, 0, 0, 0);
    wait_done(lat, bz);
    chk("add_u_out", 32'(Out), 32'h8000);
    chk("add_u_ofl", 32'(Ofl), 0);
    take();

    send(4'd4, 16'h0005, 16'h0003, 1, 0, 1, 0);
    wait_done(lat, bz);
    chk("sub_out", 32'(Out), 32'h0002);
    chk("sub_carry", 32'(Ofl), 1);
    take();

    send(4'd8, 16'hFFFF, 16'h0002, 0, 0, 0, 0);
    wait_done(lat, bz);
    chk("mul_lat", lat, 17);
    chk("mul_busy", bz, 16);
    chk("mul_lo", 32'(Out), 32'hFFFE);
    chk("mul_hi", 32'(OutHi), 32'h0001);
    chk("mul_ofl", 32'(Ofl), 1);
    take();

    send(4'd9, 16'd100, 16'd7, 0, 0, 0, 0);
    wait_done(lat, bz);
    chk("div_lat", lat, 17);
    chk("div_q", 32'(Out), 14);
    chk("div_r", 32'(OutHi), 2);
    chk("div_err", 32'(err), 0);
    take();

    send(4'd9, 16'h1234, 16'h0000, 0, 0, 0, 0);
    wait_done(lat, bz);
    chk("div0_lat", lat, 1);
    chk("div0_q", 32'(Out), 32'hFFFF);
    chk("div0_r", 32'(OutHi), 32'h1234);
    chk("div0_err", 32'(err), 1);
    take();

    send(4'd3, 16'h8000, 16'h000F, 0, 0, 0, 0);
    wait_done(lat, bz);
    chk("srl_lat", lat, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      Op = 4'd4; A = 16'h1111; B = 16'h2222;
      in_valid = 1'b1;
      chk("hold_ready", 32'(in_ready), 0);
      @(posedge clk);
      #1;
      chk("hold_valid", 32'(out_valid), 1);
      chk("hold_out", 32'(Out), 32'h0001);
    end
    in_valid = 1'b0;
    take();
    chk("srl_kept", 32'(Out), 32'h0001);

    send(4'd8, 16'h1234, 16'h5678, 0, 0, 0, 0);
    repeat (7) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("abort_ready", 32'(in_ready), 1);
    chk("abort_valid", 32'(out_valid), 0);
    chk("abort_out", 32'(Out), 0);
    chk("abort_hi", 32'(OutHi), 0);
    @(negedge clk);
    rst = 1'b1;

    send(4'd6, 16'hAAAA, 16'hAAAA, 0, 0, 0, 0);
    wait_done(lat, bz);
    chk("xor_out", 32'(Out), 0);
    chk("xor_zero", 32'(Zero), 1);
    take();

    send(4'hC, 16'h1234, 16'h4321, 0, 0, 0, 0);
    wait_done(lat, bz);
    chk("rsv_err", 32'(err), 1);
    chk("rsv_out", 32'(Out), 0);
    chk("rsv_zero", 32'(Zero), 1);
    take();

    send(4'd0, 16'h8001, 16'h0001, 0, 0, 0, 0);
    wait_done(lat, bz);
    chk("rol_out", 32'(Out), 32'h0003);
    chk("rol_err", 32'(err), 0);
    take();

    send(4'd2, 16'h0001, 16'h0004, 0, 0, 0, 0);
    wait_done(lat, bz);
    chk("ror_out", 32'(Out), 32'h1000);
    take();

    send(4'd1, 16'h0001, 16'h000F, 0, 0, 0, 0);
    wait_done(lat, bz);
    chk("sll_out", 32'(Out), 32'h8000);
    chk("sll_neg", 32'(Neg), 1);
    take();

    send(4'd7, 16'hF0F0, 16'hFF00, 0, 0, 1, 0);
    wait_done(lat, bz);
    chk("and_invb", 32'(Out), 32'h00F0);
    take();

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the 16-bit combinational ALU.
- Adds iterative unsigned multiply and divide to the existing shift, rotate and logic/add operation set.
- All results are registered behind a valid/ready interface, so the execute stage can stall on long ops.
- Sits in the execute stage between decode operand latches and the writeback mux.

Parameters:
- N, 16, operand/result width; power of two, 4..64.
- O, 4, opcode width.
- SW, $clog2(N), shift-amount width taken from B[SW-1:0].

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- in_valid  in  1  operands/op presented
- in_ready  out  1  unit can accept (state IDLE)
- A  in  N  operand A
- B  in  N  operand B
- Cin  in  1  carry-in for ADD
- Op  in  O  opcode
- invA  in  1  invert A before ADD/logic
- invB  in  1  invert B before ADD/logic
- sign  in  1  ADD overflow mode: 1 signed, 0 unsigned
- out_valid  out  1  result held
- out_ready  in  1  consumer takes result
- Out  out  N  result: low product / quotient / single-cycle result
- OutHi  out  N  high product (MUL), remainder (DIVU), else 0
- Ofl  out  1  overflow
- Zero  out  1  Out == 0
- Neg  out  1  Out[N-1]
- err  out  1  divide-by-zero or reserved opcode

Behaviour:
- Opcodes:
  - 0 ROL, 1 SLL, 2 ROR, 3 SRL
  - 4 ADD, 5 OR, 6 XOR, 7 AND
  - 8 MUL (unsigned N x N -> 2N), 9 DIVU (unsigned)
  - 10-15 reserved
- invA/invB apply to ADD and logic ops only.
- Reset (rst low, async): state IDLE; in_ready=1; out_valid=0; Out, OutHi, Ofl, Zero, Neg, err all 0.
- State machine: IDLE, BUSY, DONE.
  - IDLE: in_valid=1 accepts and captures A, B, Cin, Op, invA, invB, sign.
    - Single-cycle op, reserved op, or DIVU with B==0: compute and go to DONE. out_valid rises next cycle (latency 1).
    - MUL or DIVU with B!=0: load iteration counter with N, go to BUSY.
  - BUSY: one shift-add (MUL) or restoring-subtract (DIVU) step per cycle; counter decrements. When counter reaches 1 the final step is performed and state moves to DONE. out_valid rises N+1 cycles after acceptance.
  - DONE: out_valid=1; all outputs stable. out_ready=1 moves to IDLE, clearing out_valid next cycle. out_ready=0 holds indefinitely.
- in_ready is 1 only in IDLE. No overlap; peak throughput is one op per 2 cycles.
- Inputs are ignored outside IDLE; operand changes during BUSY do not affect the result.
- out_ready is ignored outside DONE.
- ADD: Out = A' + B' + Cin (low N bits).
  - sign=1: Ofl = (A'[N-1]==B'[N-1]) && (Out[N-1]!=A'[N-1]).
  - sign=0: Ofl = carry out of bit N-1.
- Shifts/rotates:
  - Amount is B[SW-1:0].
  - Shifts fill with 0.
  - Amount 0 passes A through.
  - Ofl=0.
- MUL: {OutHi,Out} = A*B; Ofl = (OutHi != 0).
- DIVU:
  - Out = A/B, OutHi = A%B, Ofl=0.
  - B==0: Out = all ones, OutHi = A, err=1.
- Reserved op: Out=0, OutHi=0, err=1, Ofl=0. Zero=1 follows from Out.
- Zero and Neg are always derived from the registered Out.
- Async reset asserted mid-BUSY or in DONE aborts the op; all state returns to reset values immediately.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams (OP_ROL..OP_DIVU)
  - state encodings ST_IDLE/ST_BUSY/ST_DONE
- Sub-module alu_iter_muldiv:
  - datapath: 2N-bit accumulator/remainder register plus counter
  - signals: start, mode, done pulse
- Single-cycle ops and the FSM stay in alu_seq.

Test Plan:
- Reset, then ADD with N=16, A=0x7FFF, B=0x0001, sign=1, Cin=0 -> one cycle later out_valid=1, Out=0x8000, Ofl=1, Neg=1, Zero=0. Repeat with sign=0 -> Ofl=0.
- MUL A=0xFFFF, B=0x0002 -> in_ready low for 16 cycles; out_valid exactly 17 cycles after accept; Out=0xFFFE, OutHi=0x0001, Ofl=1.
- DIVU A=100, B=7 -> Out=14, OutHi=2, err=0, latency 17. DIVU B=0, A=0x1234 -> latency 1, Out=0xFFFF, OutHi=0x1234, err=1.
- Backpressure: hold out_ready=0 for 5 cycles after SRL A=0x8000, B=0x000F -> Out=0x0001 stable throughout. in_valid with new operands during the hold is not accepted (in_ready=0). Result clears one cycle after out_ready=1.
- Assert rst low during cycle 8 of a MUL -> outputs zero and in_ready=1 immediately. After release, XOR A=0xAAAA, B=0xAAAA -> Out=0, Zero=1.
- Opcode 0xC -> err=1, Out=0, Zero=1. ROL A=0x8001, B=1 -> Out=0x0003.
